// File: rtl/player_io_pkg.sv
// Shared constants and slot storage type for the player input arbiter.
// The ts field exists only when PLAYER_TIMESTAMP_EN is defined.
package player_io_pkg;

  localparam int unsigned NUM_PLAYERS_DEF     = 4;
  localparam int unsigned DATA_W_DEF          = 8;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000;
  localparam int unsigned TS_W                = 16;
  localparam int unsigned TS_PRESCALE         = 1024;

  typedef struct packed {
    logic                  valid;
    logic [DATA_W_DEF-1:0] data;
`ifdef PLAYER_TIMESTAMP_EN
    logic [TS_W-1:0]       ts;
`endif
  } slot_t;

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser, stability counter and registered rising-edge pulse
// for one raw button input.
module input_debouncer
  import player_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;

  always_comb begin
    sync_d  = {sync_q[0], raw};
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    // Counter runs only while the synced value disagrees with the accepted level.
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync_q[1];
        rise_d  = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/player_input_arbiter.sv
// Per-player debounced submit capture into one-deep slots, round-robin drained into a
// single CPU-read output register. Define PLAYER_TIMESTAMP_EN to add capture timestamps.
module player_input_arbiter
  import player_io_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS     = NUM_PLAYERS_DEF,
  parameter int unsigned DATA_W          = DATA_W_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned ID_W            = $clog2(NUM_PLAYERS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PLAYERS-1:0]        btn,
  input  logic [NUM_PLAYERS*DATA_W-1:0] sw,
  input  logic                          rd_ack,
  output logic                          out_valid,
  output logic [ID_W-1:0]               out_id,
  output logic [DATA_W-1:0]             out_data,
`ifdef PLAYER_TIMESTAMP_EN
  output logic [TS_W-1:0]               out_ts,
`endif
  output logic [NUM_PLAYERS-1:0]        pending,
  output logic [NUM_PLAYERS-1:0]        overrun,
  input  logic                          ovr_clr
);

  logic [NUM_PLAYERS-1:0] level, cap;
  logic                   unused_level;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_deb
    input_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn[p]),
      .level(level[p]),
      .rise (cap[p])
    );
  end

  assign unused_level = ^level;

  slot_t [NUM_PLAYERS-1:0] slot_q, slot_d;
  logic [NUM_PLAYERS-1:0]  overrun_q, overrun_d;
  logic                    out_valid_q, out_valid_d;
  logic [ID_W-1:0]         out_id_q, out_id_d;
  logic [DATA_W-1:0]       out_data_q, out_data_d;
  logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic                    gnt_valid;
  logic [ID_W-1:0]         gnt_id, idx;

`ifdef PLAYER_TIMESTAMP_EN
  logic [$clog2(TS_PRESCALE)-1:0] pre_q, pre_d;
  logic [TS_W-1:0]                ts_q, ts_d, out_ts_q, out_ts_d;

  always_comb begin
    pre_d = pre_q + 1'b1;
    ts_d  = (pre_q == '1) ? ts_q + 1'b1 : ts_q;
  end
`endif

  always_comb begin
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) pending[p] = slot_q[p].valid;
  end

  // Search starts just after the last winner so every pending player is served in turn.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    for (int unsigned i = 1; i <= NUM_PLAYERS; i++) begin
      idx = ID_W'((32'(rr_ptr_q) + i) % NUM_PLAYERS);
      if (!gnt_valid && pending[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = idx;
      end
    end
  end

  always_comb begin
    slot_d      = slot_q;
    overrun_d   = overrun_q;
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_data_d  = out_data_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef PLAYER_TIMESTAMP_EN
    out_ts_d    = out_ts_q;
`endif
    if (ovr_clr) overrun_d = '0;
    if (gnt_valid && (!out_valid_q || rd_ack)) begin
      out_valid_d           = 1'b1;
      out_id_d              = gnt_id;
      out_data_d            = DATA_W'(slot_q[gnt_id].data);
`ifdef PLAYER_TIMESTAMP_EN
      out_ts_d              = slot_q[gnt_id].ts;
`endif
      slot_d[gnt_id].valid  = 1'b0;
      rr_ptr_d              = gnt_id;
    end else if (rd_ack) begin
      out_valid_d = 1'b0;
    end
    // A capture into an occupied slot is dropped; applied last so it beats ovr_clr.
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      if (cap[p]) begin
        if (slot_q[p].valid) begin
          overrun_d[p] = 1'b1;
        end else begin
          slot_d[p].valid = 1'b1;
          slot_d[p].data  = DATA_W_DEF'(sw[p*DATA_W +: DATA_W]);
`ifdef PLAYER_TIMESTAMP_EN
          slot_d[p].ts    = ts_q;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q      <= '0;
      overrun_q   <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_data_q  <= '0;
      rr_ptr_q    <= ID_W'(NUM_PLAYERS - 1);
`ifdef PLAYER_TIMESTAMP_EN
      pre_q       <= '0;
      ts_q        <= '0;
      out_ts_q    <= '0;
`endif
    end else begin
      slot_q      <= slot_d;
      overrun_q   <= overrun_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_data_q  <= out_data_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef PLAYER_TIMESTAMP_EN
      pre_q       <= pre_d;
      ts_q        <= ts_d;
      out_ts_q    <= out_ts_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_data  = out_data_q;
  assign overrun   = overrun_q;
`ifdef PLAYER_TIMESTAMP_EN
  assign out_ts    = out_ts_q;
`endif

endmodule
